simon_block_loader: RTL and testbench

Word-serial input stage that sits directly upstream of the SIMON encryption control block. It collects N-bit words from a valid/ready stream into a 2N-bit plaintext block and an M-word key, then hands the block to the encryption core with a single-cycle `newData` pulse. It uses the core's `done` level to know when the core is idle. The key is retained across blocks, so only the plaintext needs to be reloaded per block.

---
 rtl/simon_block_loader.sv | 117 +++++++++++
 tb/tb_simon_block_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_block_loader.sv
// simon_block_loader: word-serial loader that packs a 2N-bit plaintext block
// and an M-word key, then starts the SIMON core with a one-cycle newData pulse.
// Ports: clk, nR (async low reset); in_word/in_valid/in_key/in_ready stream in;
//        plain, key, newData to core; done from core; key_loaded, busy, blk_count status.
module simon_block_loader #(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic                clk,
    input  logic                nR,
    input  logic [N-1:0]        in_word,
    input  logic                in_valid,
    input  logic                in_key,
    output logic                in_ready,
    output logic [2*N-1:0]      plain,
    output logic [M-1:0][N-1:0] key,
    output logic                newData,
    input  logic                done,
    output logic                key_loaded,
    output logic                busy,
    output logic [7:0]          blk_count
);

    localparam int KW = (M > 1) ? $clog2(M) : 1;

    localparam logic [1:0] S_LOAD      = 2'd0;
    localparam logic [1:0] S_ARM       = 2'd1;
    localparam logic [1:0] S_WAIT_CLR  = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]           r_state;
    logic                 r_pc;
    logic                 r_plain_full;
    logic [KW-1:0]        r_kc;
    logic [2*N-1:0]       r_plain;
    logic [M-1:0][N-1:0]  r_key;
    logic                 r_new;
    logic                 r_key_loaded;
    logic [7:0]           r_blk;

    logic                 w_accept;
    logic                 w_kc_last;

    // Plaintext stalls once the block is full; key words keep flowing in LOAD.
    assign in_ready  = (r_state == S_LOAD) && !(!in_key && r_plain_full);
    assign busy      = (r_state != S_LOAD);
    assign w_accept  = in_valid && in_ready;
    assign w_kc_last = (r_kc == KW'(M - 1));

    assign plain      = r_plain;
    assign key        = r_key;
    assign newData    = r_new;
    assign key_loaded = r_key_loaded;
    assign blk_count  = r_blk;

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            r_state      <= S_LOAD;
            r_pc         <= 1'b0;
            r_plain_full <= 1'b0;
            r_kc         <= '0;
            r_plain      <= '0;
            r_key        <= '0;
            r_new        <= 1'b0;
            r_key_loaded <= 1'b0;
            r_blk        <= 8'd0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (in_key) begin
                            r_key[r_kc] <= in_word;
                            if (w_kc_last) begin
                                r_kc         <= '0;
                                r_key_loaded <= 1'b1;
                            end else begin
                                r_kc <= r_kc + 1'b1;
                            end
                        end else if (!r_pc) begin
                            r_plain[2*N-1:N] <= in_word;
                            r_pc             <= 1'b1;
                        end else begin
                            r_plain[N-1:0] <= in_word;
                            r_plain_full   <= 1'b1;
                        end
                    end
                    // Issue only on registered state; kc != 0 means a key
                    // reload is half done, so hold off.
                    if (r_plain_full && r_key_loaded && r_kc == '0)
                        r_state <= S_ARM;
                end
                S_ARM: begin
                    if (done) begin
                        r_new   <= 1'b1;
                        r_state <= S_WAIT_CLR;
                    end
                end
                S_WAIT_CLR: begin
                    // done is still high from the previous run here.
                    r_new <= 1'b0;
                    if (!done)
                        r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (done) begin
                        r_plain_full <= 1'b0;
                        r_pc         <= 1'b0;
                        r_blk        <= r_blk + 8'd1;
                        r_state      <= S_LOAD;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_block_loader.sv
// tb_simon_block_loader: directed bench for simon_block_loader.
// Drives #1 after rising edges, checks with immediate assertions.
module tb_simon_block_loader;

    logic              clk;
    logic              nR;
    logic [15:0]       in_word;
    logic              in_valid;
    logic              in_key;
    logic              in_ready;
    logic [31:0]       plain;
    logic [3:0][15:0]  key;
    logic              newData;
    logic              done;
    logic              key_loaded;
    logic              busy;
    logic [7:0]        blk_count;

    int tests;
    int fails;

    simon_block_loader #(.N(16), .M(4)) dut (
        .clk        (clk),
        .nR         (nR),
        .in_word    (in_word),
        .in_valid   (in_valid),
        .in_key     (in_key),
        .in_ready   (in_ready),
        .plain      (plain),
        .key        (key),
        .newData    (newData),
        .done       (done),
        .key_loaded (key_loaded),
        .busy       (busy),
        .blk_count  (blk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a word until it is accepted (bounded).
    task automatic send(input logic k, input logic [15:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_key   = k;
        in_word  = w;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_key   = 1'b0;
    endtask

    // Load a plaintext block and walk the core handshake to completion.
    task automatic run_block(input logic [15:0] hi, input logic [15:0] lo);
        int n;
        send(1'b0, hi);
        send(1'b0, lo);
        n = 0;
        while (!newData && n < 20) begin
            tick();
            n++;
        end
        chk("blk_pulse", 64'(newData), 64'd1);
        done = 1'b0;
        tick();
        done = 1'b1;
        tick();
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        nR       = 1'b0;
        in_word  = '0;
        in_valid = 1'b0;
        in_key   = 1'b0;
        done     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_plain", 64'(plain), 64'd0);
        chk("rst_key", key, 64'd0);
        chk("rst_new", 64'(newData), 64'd0);
        chk("rst_kl", 64'(key_loaded), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_blk", 64'(blk_count), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        nR = 1'b1;
        tick();

        // SIMON32/64 vector, done held high.
        send(1'b1, 16'h0100);
        send(1'b1, 16'h0908);
        send(1'b1, 16'h1110);
        send(1'b1, 16'h1918);
        chk("kl_set", 64'(key_loaded), 64'd1);
        send(1'b0, 16'h6565);
        send(1'b0, 16'h6877);
        chk("v_key", key, 64'h1918_1110_0908_0100);
        chk("v_plain", 64'(plain), 64'h65656877);
        chk("v_busy_t", 64'(busy), 64'd0);
        chk("v_ready_full", 64'(in_ready), 64'd0);
        tick();
        chk("v_busy_arm", 64'(busy), 64'd1);
        chk("v_new_t1", 64'(newData), 64'd0);
        chk("v_ready_arm", 64'(in_ready), 64'd0);
        tick();
        chk("v_new_t2", 64'(newData), 64'd1);

        // Stale done: high 3 more cycles, low 20, then high.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stale_new", 64'(newData), 64'd0);
            chk("stale_blk", 64'(blk_count), 64'd0);
        end
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("low_new", 64'(newData), 64'd0);
            chk("low_busy", 64'(busy), 64'd1);
        end
        chk("low_blk", 64'(blk_count), 64'd0);
        done = 1'b1;
        tick();
        chk("cmp_blk", 64'(blk_count), 64'd1);
        chk("cmp_busy", 64'(busy), 64'd0);
        chk("cmp_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_new", 64'(newData), 64'd0);
        end

        // Key retention: plaintext only.
        send(1'b0, 16'h0000);
        send(1'b0, 16'h0001);
        tick();
        chk("r_new_t1", 64'(newData), 64'd0);
        tick();
        chk("r_new_t2", 64'(newData), 64'd1);
        chk("r_key", key, 64'h1918_1110_0908_0100);
        chk("r_plain", 64'(plain), 64'h00000001);
        done = 1'b0;
        tick();
        done = 1'b1;
        tick();
        chk("r_blk", 64'(blk_count), 64'd2);

        // Partial key reload blocks issue; plaintext backpressure.
        send(1'b1, 16'haaaa);
        send(1'b1, 16'hbbbb);
        send(1'b0, 16'h1234);
        send(1'b0, 16'h5678);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pk_new", 64'(newData), 64'd0);
            chk("pk_busy", 64'(busy), 64'd0);
        end
        in_valid = 1'b1;
        in_key   = 1'b0;
        in_word  = 16'hdead;
        #1;
        chk("bp_ready", 64'(in_ready), 64'd0);
        tick();
        chk("bp_plain", 64'(plain), 64'h12345678);
        in_key = 1'b1;
        #1;
        chk("bp_key_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        in_key   = 1'b0;
        send(1'b1, 16'hcccc);
        send(1'b1, 16'hdddd);
        tick();
        chk("pk_new_t1", 64'(newData), 64'd0);
        tick();
        chk("pk_new_t2", 64'(newData), 64'd1);
        chk("pk_key", key, 64'hdddd_cccc_bbbb_aaaa);
        chk("pk_plain", 64'(plain), 64'h12345678);

        // Reset while in WAIT_CLR.
        nR = 1'b0;
        #1;
        chk("mr_new", 64'(newData), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_key", key, 64'd0);
        chk("mr_plain", 64'(plain), 64'd0);
        chk("mr_kl", 64'(key_loaded), 64'd0);
        chk("mr_blk", 64'(blk_count), 64'd0);
        tick();
        nR = 1'b1;
        tick();

        send(1'b1, 16'h0100);
        send(1'b1, 16'h0908);
        send(1'b1, 16'h1110);
        send(1'b1, 16'h1918);
        send(1'b0, 16'h6565);
        send(1'b0, 16'h6877);
        tick();
        chk("pr_new_t1", 64'(newData), 64'd0);
        tick();
        chk("pr_new_t2", 64'(newData), 64'd1);
        chk("pr_key", key, 64'h1918_1110_0908_0100);
        done = 1'b0;
        tick();
        done = 1'b1;
        tick();
        chk("pr_blk", 64'(blk_count), 64'd1);

        // Counter wrap 255 -> 0.
        for (int i = 0; i < 254; i++)
            run_block(16'(i), 16'hffff);
        chk("w_255", 64'(blk_count), 64'd255);
        run_block(16'h0bad, 16'hf00d);
        chk("w_0", 64'(blk_count), 64'd0);
        chk("w_kl", 64'(key_loaded), 64'd1);
        chk("w_plain", 64'(plain), 64'h0badf00d);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
